imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Program loader that sits directly upstream of the CPU's instruction memory. It replaces hierarchical pre-loading of instruction memory with a real byte-stream path.
- Receives a framed byte stream over a valid/ready interface and assembles big-endian 32-bit instruction words.
- Writes each word to instruction memory at consecutive word addresses starting at 0.
- Holds the CPU in reset until the whole program has loaded and its checksum has passed.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; capacity = 2**ADDR_WIDTH words

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  single-cycle pulse; begins a load. Honoured only in IDLE, DONE, ERROR
rx_data  in  8  stream byte
rx_valid  in  1  rx_data is valid
rx_ready  out  1  loader accepts a byte this cycle
imem_we  out  1  instruction-memory write enable
imem_addr  out  ADDR_WIDTH  word address (byte address >> 2)
imem_wdata  out  32  instruction word
cpu_reset  out  1  active-high reset to the CPU
busy  out  1  load in progress
done  out  1  last load succeeded
error  out  1  last load failed
words_loaded  out  16  words written in the current or last load

Behaviour:
- Frame format, in byte order:
  - LEN_HI, LEN_LO: N, 16-bit word count.
  - N words of 4 bytes each, MSB first.
  - CHK: XOR of every preceding byte in the frame, including both length bytes.
- Handshake: a byte transfers on a rising edge where rx_valid && rx_ready. rx_valid may drop at any time; the loader state does not advance without a transfer.
- Reset (reset==0 sampled at an edge):
  - state=IDLE; cpu_reset=1.
  - rx_ready, imem_we, busy, done, error = 0.
  - imem_addr, imem_wdata, words_loaded, checksum accumulator, byte index all = 0.
- States and transitions:
  - IDLE: cpu_reset=1. On start: go to LEN_HI, busy=1, clear counters and accumulator.
  - LEN_HI, LEN_LO: rx_ready=1. Latch the length bytes.
  - After LEN_LO:
    - N > 2**ADDR_WIDTH: go to ERROR.
    - N == 0: go to CHECK.
    - Otherwise: go to WORD.
  - WORD: rx_ready=1. A 2-bit byte index shifts bytes into a word register MSB first. Transferring byte 3 goes to WRITE.
  - WRITE: exactly one cycle.
    - rx_ready=0; imem_we=1; imem_addr=words_loaded[ADDR_WIDTH-1:0]; imem_wdata=assembled word.
    - words_loaded increments at the end of the cycle.
    - Next state is CHECK if the incremented count == N, else WORD.
  - CHECK: rx_ready=1. On transfer: go to DONE if rx_data == accumulator, else ERROR.
  - DONE: done=1, busy=0, cpu_reset=0, rx_ready=0.
  - ERROR: error=1, busy=0, cpu_reset=1, rx_ready=0.
  - From DONE or ERROR, start restarts at LEN_HI:
    - done and error clear, busy=1.
    - cpu_reset=1 from the next cycle.
    - Instruction memory is not cleared.
- Output timing: all outputs are registered. cpu_reset falls on the same edge that enters DONE, so the CPU runs from PC=0 one cycle later.
- Byte-to-write latency: imem_we is high in the cycle immediately after the 4th byte of a word transfers.
- A start pulse while busy is ignored.
- Bytes offered in IDLE, DONE or ERROR are not accepted, because rx_ready=0 in those states.
- Accumulator: 8-bit XOR over all transferred bytes except CHK itself.
- Reset mid-load: return immediately to reset values. Partially written memory is left as is. The CPU stays in reset.

Test Plan:
- Two-word load, rx_valid held high. After start, send bytes 00 02 20 08 00 06 20 09 00 0B 0E.
  - Writes: addr0=0x20080006, addr1=0x2009000B.
  - Each imem_we is a one-cycle pulse.
  - Then done=1, cpu_reset=0, words_loaded=2, error=0.
- Same frame with rx_valid toggled high/low every other cycle: identical writes and final state.
  - No byte is duplicated or dropped.
  - rx_ready=0 in each WRITE cycle.
- Same frame with CHK=0x0F:
  - Both writes still occur.
  - Then error=1, done=0, cpu_reset stays 1.
- Length 01 01 (257 > 256):
  - ERROR right after LEN_LO; no imem_we pulses.
  - Later bytes are not accepted (rx_ready=0).
- Zero length, frame 00 00 00:
  - done=1, words_loaded=0, no writes.
- Reset low during the 3rd byte of word 1, then released:
  - IDLE, cpu_reset=1, busy=0, words_loaded=0.
  - A fresh start followed by the two-word frame completes normally.
- A second start after DONE:
  - cpu_reset returns to 1 and busy=1.
  - The loaded 44-word Fibonacci image is written to addresses 0..43; done=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Loads a program into the CPU's instruction memory from a framed byte stream
// and holds the CPU in reset until the whole program has arrived with a good
// checksum.
//
// Frame (byte order): LEN_HI, LEN_LO (N words), N x 4 bytes MSB first, CHK.
// CHK is the XOR of every preceding byte of the frame, length bytes included.
//
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous, active-low reset
//   start         one-cycle pulse that begins a load (IDLE, DONE, ERROR only)
//   rx_data       stream byte
//   rx_valid      rx_data is valid
//   rx_ready      loader accepts a byte this cycle
//   imem_we       instruction-memory write enable (one-cycle pulse per word)
//   imem_addr     instruction-memory word address
//   imem_wdata    assembled big-endian instruction word
//   cpu_reset     active-high reset to the CPU, low only after a good load
//   busy          load in progress
//   done          last load succeeded
//   error         last load failed (bad length or bad checksum)
//   words_loaded  words written in the current or last load
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    // Memory capacity in words, one bit wider than the length field so that
    // a full 16-bit address space still compares correctly.
    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        WORD,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] len;
    logic [15:0] len_next;
    logic [7:0]  acc;
    logic [7:0]  acc_next;
    logic [1:0]  byte_idx;
    logic [1:0]  byte_idx_next;
    logic [31:0] word;
    logic [31:0] word_next;
    logic [15:0] count;
    logic [15:0] count_next;

    logic        rx_ready_next;
    logic        imem_we_next;
    logic        cpu_reset_next;
    logic        busy_next;
    logic        done_next;
    logic        error_next;

    logic        xfer;
    logic [15:0] len_rx;

    assign xfer   = rx_valid && rx_ready;
    // Complete length as it stands while LEN_LO is being transferred.
    assign len_rx = {len[15:8], rx_data};

    // The word shift register doubles as the write-data output: it holds the
    // finished word throughout the WRITE cycle. The address is the count of
    // words already written, which advances at the end of WRITE.
    assign imem_wdata   = word;
    assign words_loaded = count;
    assign imem_addr    = count[ADDR_WIDTH-1:0];

    // Next-state and next-output logic. Outputs are decoded from the next
    // state and registered, so every output changes on the same edge as the
    // state it belongs to (cpu_reset falls on the edge that enters DONE).
    always_comb begin
        state_next    = state;
        len_next      = len;
        acc_next      = acc;
        byte_idx_next = byte_idx;
        word_next     = word;
        count_next    = count;

        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_next    = LEN_HI;
                    len_next      = 16'h0000;
                    acc_next      = 8'h00;
                    byte_idx_next = 2'd0;
                    word_next     = 32'h0000_0000;
                    count_next    = 16'h0000;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_next   = {rx_data, 8'h00};
                    acc_next   = acc ^ rx_data;
                    state_next = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_next = len_rx;
                    acc_next = acc ^ rx_data;
                    if ({1'b0, len_rx} > CAPACITY) begin
                        state_next = ERROR;
                    end else if (len_rx == 16'h0000) begin
                        state_next = CHECK;
                    end else begin
                        state_next = WORD;
                    end
                end
            end
            WORD: begin
                if (xfer) begin
                    word_next     = {word[23:0], rx_data};
                    acc_next      = acc ^ rx_data;
                    byte_idx_next = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                count_next = count + 16'd1;
                state_next = (count_next == len) ? CHECK : WORD;
            end
            CHECK: begin
                if (xfer) begin
                    state_next = (rx_data == acc) ? DONE : ERROR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        rx_ready_next  = (state_next == LEN_HI) || (state_next == LEN_LO) ||
                         (state_next == WORD)   || (state_next == CHECK);
        imem_we_next   = (state_next == WRITE);
        busy_next      = (state_next != IDLE) && (state_next != DONE) &&
                         (state_next != ERROR);
        done_next      = (state_next == DONE);
        error_next     = (state_next == ERROR);
        cpu_reset_next = (state_next != DONE);
    end

    // State, datapath and output registers. A reset mid-load abandons the
    // frame; whatever already reached memory is left there.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            len       <= 16'h0000;
            acc       <= 8'h00;
            byte_idx  <= 2'd0;
            word      <= 32'h0000_0000;
            count     <= 16'h0000;
            rx_ready  <= 1'b0;
            imem_we   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
        end else begin
            state     <= state_next;
            len       <= len_next;
            acc       <= acc_next;
            byte_idx  <= byte_idx_next;
            word      <= word_next;
            count     <= count_next;
            rx_ready  <= rx_ready_next;
            imem_we   <= imem_we_next;
            busy      <= busy_next;
            done      <= done_next;
            error     <= error_next;
            cpu_reset <= cpu_reset_next;
        end
    end

endmodule
